// File: rtl/aurora_pkg.sv
// Shared widths and write-FSM state encoding for the Aurora RX packet buffer.
package aurora_pkg;

    localparam int AURORA_DATA_W = 128;
    localparam int AURORA_KEEP_W = 16;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PKT  = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/aurora_rx_pkt_buffer_sdp_ram.sv
// Simple dual-port packet storage: {tkeep, tdata} words plus a tlast bit.
// Read data is registered and holds while rd_en_i is low.
module sdp_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 144,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_last_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_last_o
);

    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic             last_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_last_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i]  <= wr_data_i;
            last_q[wr_addr_i] <= wr_last_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
            rd_last_q <= last_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_last_o = rd_last_q;

endmodule

// File: rtl/aurora_rx_pkt_buffer.sv
// Store-and-forward packet buffer for an Aurora RX stream without backpressure.
// Statistics counters are built only when AURORA_RX_PKT_BUFFER_STAT_EN is defined.
//
//   state   | meaning
//   WR_IDLE | waiting for a packet start
//   WR_PKT  | storing a packet
//   WR_DROP | discarding the remainder of a packet
module aurora_rx_pkt_buffer
    import aurora_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     channel_up,
    input  logic [AURORA_DATA_W-1:0] rx_tdata,
    input  logic [AURORA_KEEP_W-1:0] rx_tkeep,
    input  logic                     rx_tvalid,
    input  logic                     rx_tlast,
    output logic [AURORA_DATA_W-1:0] m_tdata,
    output logic [AURORA_KEEP_W-1:0] m_tkeep,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         pkt_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int RAM_W = AURORA_KEEP_W + AURORA_DATA_W;
    localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_FULL = {1'b1, {AW{1'b0}}};

    wr_state_e   state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] cm_ptr_q, cm_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic          full;
    logic          readable;
    logic          wr_en;
    logic          rd_en;
    logic          rd_vld_q;
    logic          out_load;
    logic [RAM_W-1:0] ram_rd_data;
    logic          ram_rd_last;

    logic [AURORA_DATA_W-1:0] m_tdata_q;
    logic [AURORA_KEEP_W-1:0] m_tkeep_q;
    logic                     m_tvalid_q;
    logic                     m_tlast_q;

    assign full     = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
    assign readable = rd_ptr_q != cm_ptr_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        wr_en    = 1'b0;
        if (!channel_up) begin
            if (state_q == WR_PKT) begin
                wr_ptr_d = cm_ptr_q;
            end
            state_d = WR_IDLE;
        end else begin
            case (state_q)
                WR_IDLE, WR_PKT: begin
                    if (rx_tvalid) begin
                        if (!full) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            if (rx_tlast) begin
                                cm_ptr_d = wr_ptr_q + PTR_ONE;
                                state_d  = WR_IDLE;
                            end else begin
                                state_d  = WR_PKT;
                            end
                        end else begin
                            wr_ptr_d = cm_ptr_q;
                            state_d  = rx_tlast ? WR_IDLE : WR_DROP;
                        end
                    end
                end
                WR_DROP: begin
                    if (rx_tvalid && rx_tlast) begin
                        state_d = WR_IDLE;
                    end
                end
                default: state_d = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WR_IDLE;
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
        end
    end

    // Fetch ahead only while the sink is accepting, so a stalled output pins
    // at most one word outside the RAM and full stays close to true occupancy.
    assign out_load = rd_vld_q & (~m_tvalid_q | m_tready);
    assign rd_en    = readable &
                      ((~rd_vld_q & ~m_tvalid_q) | (m_tready & (~rd_vld_q | out_load)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                rd_vld_q <= 1'b1;
            end else if (out_load) begin
                rd_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
        end else if (out_load) begin
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= ram_rd_last;
            m_tkeep_q  <= ram_rd_data[RAM_W-1:AURORA_DATA_W];
            m_tdata_q  <= ram_rd_data[AURORA_DATA_W-1:0];
        end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;

    sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RAM_W),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({rx_tkeep, rx_tdata}),
        .wr_last_i (rx_tlast),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (ram_rd_data),
        .rd_last_o (ram_rd_last)
    );

`ifdef AURORA_RX_PKT_BUFFER_STAT_EN
    logic             pkt_inc;
    logic             drop_inc;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    assign pkt_inc  = wr_en & rx_tlast;
    assign drop_inc = channel_up ? (rx_tvalid & full & (state_q != WR_DROP))
                                 : (state_q == WR_PKT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pkt_inc) begin
                pkt_cnt_q <= pkt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (drop_inc) begin
                drop_cnt_q <= drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_aurora_rx_pkt_buffer.sv
// Directed bench for aurora_rx_pkt_buffer with DEPTH=16; output words are
// checked against a queue of expected words filled as packets are sent.
`timescale 1ns/1ps
module tb_aurora_rx_pkt_buffer;
    import aurora_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
`ifdef AURORA_RX_PKT_BUFFER_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     channel_up;
    logic [AURORA_DATA_W-1:0] rx_tdata;
    logic [AURORA_KEEP_W-1:0] rx_tkeep;
    logic                     rx_tvalid;
    logic                     rx_tlast;
    logic [AURORA_DATA_W-1:0] m_tdata;
    logic [AURORA_KEEP_W-1:0] m_tkeep;
    logic                     m_tvalid;
    logic                     m_tlast;
    logic                     m_tready;
    logic [CNT_W-1:0]         drop_cnt;
    logic [CNT_W-1:0]         pkt_cnt;

    always #5 clk = ~clk;

    aurora_rx_pkt_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .channel_up (channel_up),
        .rx_tdata   (rx_tdata),
        .rx_tkeep   (rx_tkeep),
        .rx_tvalid  (rx_tvalid),
        .rx_tlast   (rx_tlast),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .drop_cnt   (drop_cnt),
        .pkt_cnt    (pkt_cnt)
    );

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;
    int exp_pkt  = 0;
    logic [144:0] exp_q[$];

    typedef struct {
        int id;
        int len;
        bit deliver;
        int drop_inc;
        int pkt_inc;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [127:0] mk_data(input int id, input int idx);
        return {id, idx, 32'hC0DE_F00D, ~id};
    endfunction

    function automatic logic [15:0] mk_keep(input int id, input int idx, input int len);
        logic [15:0] all_k;
        all_k = 16'hFFFF;
        return (idx == len - 1) ? (all_k >> (id % 16)) : all_k;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name);
        check({name, "_drop_cnt"}, 160'(drop_cnt), 160'(STAT ? exp_drop : 0));
        check({name, "_pkt_cnt"},  160'(pkt_cnt),  160'(STAT ? exp_pkt : 0));
    endtask

    // cu_off_at: word index at which channel_up is dropped for the rest of the packet (-1: never)
    task automatic send_pkt(input int id, input int len, input int cu_off_at, input bit deliver);
        for (int i = 0; i < len; i++) begin
            if (i == cu_off_at) channel_up = 1'b0;
            rx_tvalid = 1'b1;
            rx_tdata  = mk_data(id, i);
            rx_tkeep  = mk_keep(id, i, len);
            rx_tlast  = (i == len - 1);
            if (deliver) exp_q.push_back({rx_tlast, rx_tkeep, rx_tdata});
            @(posedge clk); #1;
        end
        rx_tvalid  = 1'b0;
        rx_tlast   = 1'b0;
        channel_up = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check(name, 160'(exp_q.size()), 160'(0));
    endtask

    // Output monitor: every transfer must match the next expected word, and a
    // stalled word must stay put until it is taken.
    logic         prev_stall = 1'b0;
    logic [144:0] prev_word  = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall)
                check("stall_hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, prev_word});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected no word", {m_tlast, m_tkeep, m_tdata});
                end else begin
                    check("out_word", {m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
                end
            end
            prev_stall <= m_tvalid && !m_tready;
            prev_word  <= {m_tlast, m_tkeep, m_tdata};
        end else begin
            prev_stall <= 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{10,  1, 1'b1, 0, 1};
        vecs[1] = '{11, 16, 1'b1, 0, 1};
        vecs[2] = '{12, 17, 1'b0, 1, 0};
        vecs[3] = '{13, 20, 1'b0, 1, 0};
        vecs[4] = '{14,  4, 1'b1, 0, 1};
        vecs[5] = '{15,  2, 1'b1, 0, 1};

        reset_n    = 1'b0;
        channel_up = 1'b1;
        rx_tvalid  = 1'b0;
        rx_tdata   = '0;
        rx_tkeep   = '0;
        rx_tlast   = 1'b0;
        m_tready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 160'(m_tvalid), 160'(0));
        check("rst_tlast",  160'(m_tlast),  160'(0));
        check("rst_tdata",  160'(m_tdata),  160'(0));
        check("rst_tkeep",  160'(m_tkeep),  160'(0));
        check_cnt("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 3-word packet: latency from commit edge and back-to-back output
        send_pkt(1, 3, -1, 1'b1);
        check("lat_commit", 160'(m_tvalid), 160'(0));
        @(posedge clk); #1;
        check("lat_c1", 160'(m_tvalid), 160'(0));
        @(posedge clk); #1;
        check("lat_c2", 160'(m_tvalid), 160'(1));
        @(posedge clk); #1;
        check("seq_w2_valid", 160'(m_tvalid), 160'(1));
        @(posedge clk); #1;
        check("seq_w3_valid", 160'(m_tvalid), 160'(1));
        check("seq_w3_last",  160'(m_tlast),  160'(1));
        @(posedge clk); #1;
        check("seq_end_valid", 160'(m_tvalid), 160'(0));
        exp_pkt = 1;
        wait_drain("p1_drain");
        check_cnt("p1");

        for (int i = 0; i < 6; i++) begin
            send_pkt(vecs[i].id, vecs[i].len, -1, vecs[i].deliver);
            wait_drain($sformatf("vec%0d_drain", i));
            exp_drop += vecs[i].drop_inc;
            exp_pkt  += vecs[i].pkt_inc;
            check_cnt($sformatf("vec%0d", i));
        end

        // Stalled sink: four 4-word packets fill the buffer, a fifth is dropped
        m_tready = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(20 + p, 4, -1, 1'b1);
        send_pkt(24, 2, -1, 1'b0);
        exp_pkt  += 4;
        exp_drop += 1;
        check_cnt("bp");
        check("bp_hold_valid", 160'(m_tvalid), 160'(1));
        check("bp_hold_data",  160'(m_tdata),  160'(mk_data(20, 0)));
        repeat (3) begin
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        wait_drain("bp_drain");

        // Link drop inside a packet, then a clean packet
        send_pkt(30, 5, 2, 1'b0);
        exp_drop += 1;
        wait_drain("cu_drain");
        check_cnt("cu");
        @(posedge clk); #1;
        send_pkt(31, 3, -1, 1'b1);
        exp_pkt += 1;
        wait_drain("cu_next_drain");
        check_cnt("cu_next");

        // Ready toggling 1010... over a 6-word packet
        m_tready = 1'b0;
        send_pkt(40, 6, -1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            m_tready = (k % 2 == 0);
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        exp_pkt += 1;
        wait_drain("tog_drain");
        check_cnt("tog");

        // Reset while a packet is streaming out
        send_pkt(50, 12, -1, 1'b1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_rst_valid", 160'(m_tvalid), 160'(1));
        reset_n = 1'b0;
        exp_q.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        @(posedge clk); #1;
        check("mid_rst_valid", 160'(m_tvalid), 160'(0));
        check("mid_rst_tdata", 160'(m_tdata),  160'(0));
        check_cnt("mid_rst");
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_pkt(51, 3, -1, 1'b1);
        exp_pkt = 1;
        wait_drain("post_rst_drain");
        check_cnt("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aurora_rx_pkt_buffer.md
AURORA_RX_PKT_BUFFER -- requirements
Module: aurora_rx_pkt_buffer

Interface
REQ-001 Parameter DEPTH, default 512: buffer depth in 128-bit words; power of two, minimum 16.
REQ-002 Parameter CNT_W, default 32: width of the statistics counters.
REQ-003 clk  in  1  Aurora user clock; all logic is in this domain.
REQ-004 reset_n  in  1  Asynchronous active-low reset; deasserted synchronously to clk by the instantiating level.
REQ-005 channel_up  in  1  Aurora channel status; low means the link is down.
REQ-006 rx_tdata  in  128  Aurora RX data; the source has no backpressure.
REQ-007 rx_tkeep  in  16  Aurora RX byte qualifiers.
REQ-008 rx_tvalid  in  1  Aurora RX word valid.
REQ-009 rx_tlast  in  1  Aurora RX end of packet.
REQ-010 m_tdata  out  128  Buffered packet data.
REQ-011 m_tkeep  out  16  Buffered byte qualifiers.
REQ-012 m_tvalid  out  1  Output word valid.
REQ-013 m_tlast  out  1  Output end of packet.
REQ-014 m_tready  in  1  Downstream ready.
REQ-015 drop_cnt  out  CNT_W  Number of packets discarded.
REQ-016 pkt_cnt  out  CNT_W  Number of packets committed.

Function
REQ-017 Store-and-forward: no word of a packet SHALL appear on m_* before its rx_tlast word is written and committed.
REQ-018 Pointers SHALL be log2(DEPTH)+1 bits wide:
- wr_ptr: tentative write pointer.
- cm_ptr: commit pointer.
- rd_ptr: read pointer.
REQ-019 Full SHALL be (wr_ptr - rd_ptr) == DEPTH; readable SHALL be rd_ptr != cm_ptr; all pointer arithmetic wraps modulo 2^(log2(DEPTH)+1).
REQ-020 The write FSM SHALL have three states:
- WR_IDLE: waiting for a packet start.
- WR_PKT: storing a packet.
- WR_DROP: discarding the remainder of a packet.
REQ-021 WR_IDLE/WR_PKT, rx_tvalid & channel_up & !full: write the word at wr_ptr and increment wr_ptr.
- Without rx_tlast: go to WR_PKT.
- With rx_tlast: set cm_ptr to the new wr_ptr, increment pkt_cnt and go to WR_IDLE.
REQ-022 WR_IDLE/WR_PKT, rx_tvalid & full: write nothing, restore wr_ptr to cm_ptr and increment drop_cnt.
- Without rx_tlast: go to WR_DROP.
- With rx_tlast: go to WR_IDLE.
REQ-023 WR_DROP: ignore all words; a word with rx_tvalid & rx_tlast SHALL return the FSM to WR_IDLE.
REQ-024 channel_up low in WR_PKT SHALL restore wr_ptr to cm_ptr, increment drop_cnt once and go to WR_IDLE; in other states it only forces WR_IDLE. Words received while channel_up is low SHALL be ignored.
REQ-025 The read side SHALL be a show-ahead output register fed by a 1-cycle RAM read; a transfer occurs when m_tvalid & m_tready.
REQ-026 m_tvalid SHALL NOT drop and m_* SHALL NOT change while m_tvalid & !m_tready.
REQ-027 The output SHALL sustain one word per cycle while data is readable and m_tready is high.
REQ-028 Latency: a committed single-word packet into an empty buffer SHALL assert m_tvalid 2 cycles after its commit edge.
REQ-029 A read and a write in the same cycle SHALL both proceed; full is evaluated before that cycle's read.
REQ-030 Counters SHALL wrap at 2^CNT_W.

Reset
REQ-031 reset_n low SHALL set all pointers to 0, the FSM to WR_IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, m_tkeep=0, drop_cnt=0 and pkt_cnt=0.
REQ-032 Reset mid-packet SHALL discard all buffered and partial packets; RAM contents are not cleared.

Configuration
REQ-033 The macro AURORA_RX_PKT_BUFFER_STAT_EN SHALL control the statistics counters:
- Defined: drop_cnt and pkt_cnt count as specified in REQ-021, REQ-022, REQ-024 and REQ-030.
- Undefined: no counter registers are built and drop_cnt and pkt_cnt are constant 0; all other behaviour is unchanged.

Structure
REQ-034 Package aurora_pkg SHALL hold AURORA_DATA_W=128, AURORA_KEEP_W=16 and the write FSM state enum.
REQ-035 Storage SHALL be one sub-module, sdp_ram: simple dual-port RAM, DEPTH x 144 bits ({tkeep, tdata}), registered read, plus a tlast bit.

Verification
REQ-036 The bench SHALL use DEPTH=16 and cover:
- Send a 3-word packet with m_tready=1 -> m_tvalid at commit+2, 3 consecutive words, m_tlast on word 3, pkt_cnt=1.
- Send a 20-word packet -> nothing output, drop_cnt=1, pointers restored; a following 4-word packet is output intact.
- Hold m_tready=0 and send four 4-word packets -> all 4 packets buffered; a fifth 2-word packet is dropped (drop_cnt=1); releasing m_tready outputs 16 words in order.
- Drop channel_up after word 2 of a 5-word packet -> drop_cnt=1, no output; the next packet is output intact.
- Toggle m_tready 1010... over a 6-word packet -> each word is transferred exactly once and m_tdata is stable while stalled.
- Assert reset_n low mid-output -> m_tvalid=0 the next cycle, counters=0, a new packet is handled normally.
